pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; successor to the fixed-field inter-stage latches between decode, execute and memory.
- Carries a CTRL payload and a DATA payload under a valid/ready handshake.
  - CTRL: write enables, op codes; forced to a NOP value when the slot is empty.
  - DATA: operands, addresses; held when the slot is empty.
- Supports flush (branch/exception kill) and backpressure (stall).
- Optional 2-entry skid mode registers in_ready, so the stall path does not chain across stages.

Parameters:
- CTRL_W, 8, width of control payload.
- DATA_W, 64, width of data payload.
- CTRL_NOP, {CTRL_W{1'b0}}, control value presented whenever out_valid=0 (bubble = NOP, all write/read enables off).
- SKID, 1, 0 = single register with combinational in_ready; 1 = main + skid register with registered in_ready.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_ctrl  in  CTRL_W  upstream control payload.
- in_data  in  DATA_W  upstream data payload.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_ctrl  out  CTRL_W  control payload; equals CTRL_NOP when out_valid=0.
- out_data  out  DATA_W  data payload; holds its last value when out_valid=0.
- occ  out  2  entries held: 0..1 if SKID=0, 0..2 if SKID=1.

Behaviour:
- Reset is synchronous, active-high; clock is clk. Register reset applies to every output:
  - out_valid=0, out_ctrl=CTRL_NOP, out_data=0, occ=0.
  - in_ready=1 in the first cycle after reset.
  - rst has priority over flush and over all handshakes.
  - Reset mid-operation discards every held entry.
- Handshakes:
  - Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - out_valid, once high, stays high with stable payload until the output transfer.
  - in_ctrl and in_data are ignored when in_valid=0.
- Latency: an accepted beat appears at the output one cycle later when the stage is empty. Beats leave in arrival order; none is dropped or duplicated except by flush.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - On an input transfer: payload is loaded and out_valid<=1.
  - On an output transfer with no input transfer: out_valid<=0 and out_ctrl<=CTRL_NOP.
  - Full throughput of 1 beat per cycle under continuous out_ready.
- SKID=1, FSM over occ:
  - EMPTY (occ=0):
    - in_ready=1.
    - Input transfer -> main loaded, go to HALF.
  - HALF (occ=1):
    - in_ready=1.
    - Input and output transfer in the same cycle -> main reloaded, stay HALF.
    - Input transfer only -> beat goes to skid, go to FULL.
    - Output transfer only -> go to EMPTY.
  - FULL (occ=2):
    - in_ready=0.
    - Output transfer -> skid moves to main, go to HALF.
    - in_valid is ignored in this state.
  - in_ready is a flop: 1 in EMPTY/HALF, 0 in FULL. It is never a function of out_ready in the same cycle.
  - Throughput is 1 beat per cycle when out_ready=1.
- Flush (when rst=0):
  - Next cycle: occ=0, out_valid=0, out_ctrl=CTRL_NOP, in_ready=1. out_data is not cleared.
  - A beat presented in the flush cycle is discarded even if in_ready=1; upstream treats it as consumed.
  - An output transfer in the flush cycle completes normally; the downstream stage sees it.
- Bubble rule: out_ctrl must equal CTRL_NOP in every cycle where out_valid=0, including cycles after a drain or a flush.
- Width rule: payloads pass through bit-exact. There is no arithmetic in the block.

Test Plan:
- Reset, CTRL_W=8, DATA_W=64, SKID=1:
  - Assert rst 2 cycles while in_valid=1 and in_ctrl=8'hA5 -> out_valid=0, out_ctrl=8'h00, out_data=0, occ=0, in_ready=1 on the first cycle after release.
- Streaming:
  - out_ready=1; 10 back-to-back beats with data=i, ctrl=8'h10+i -> each beat out exactly 1 cycle after acceptance, in order, in_ready never 0, occ stays 1.
- Backpressure:
  - out_ready=0; send A, B, C -> A and B accepted, occ=2, in_ready=0, C held upstream.
  - Raise out_ready -> output sequence A, B, C with no gaps; in_ready returns to 1 one cycle after the first drain.
- Flush in FULL:
  - occ=2; assert flush with out_ready=0 and in_valid=1 carrying D -> next cycle occ=0, out_valid=0, out_ctrl=8'h00, D never appears.
- Reset mid-drain:
  - occ=2, out_ready=1; assert rst -> no held beat appears afterwards; outputs at reset values.
- SKID=0 variant:
  - Hold out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle.
  - Toggle out_ready every cycle under continuous input -> no loss, order preserved, out_ctrl=CTRL_NOP whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush and an
// optional two-entry skid buffer that registers in_ready.
module pipe_stage_reg #(
    parameter int                CTRL_W   = 8,
    parameter int                DATA_W   = 64,
    parameter logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}},
    parameter int                SKID     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    generate
        if (SKID == 0) begin : g_single
            logic              valid_r;
            logic [CTRL_W-1:0] ctrl_r;
            logic [DATA_W-1:0] data_r;
            logic              in_xfer_s;
            logic              out_xfer_s;

            assign in_ready   = ~valid_r | out_ready;
            assign in_xfer_s  = in_valid & in_ready;
            assign out_xfer_s = valid_r & out_ready;

            // Single slot: load on accept, drop to a NOP bubble on drain.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_r <= 1'b0;
                    ctrl_r  <= CTRL_NOP;
                    data_r  <= {DATA_W{1'b0}};
                end else if (flush) begin
                    valid_r <= 1'b0;
                    ctrl_r  <= CTRL_NOP;
                end else if (in_xfer_s) begin
                    valid_r <= 1'b1;
                    ctrl_r  <= in_ctrl;
                    data_r  <= in_data;
                end else if (out_xfer_s) begin
                    valid_r <= 1'b0;
                    ctrl_r  <= CTRL_NOP;
                end else begin
                    valid_r <= valid_r;
                end
            end

            assign out_valid = valid_r;
            assign out_ctrl  = ctrl_r;
            assign out_data  = data_r;
            assign occ       = {1'b0, valid_r};
        end else begin : g_skid
            state_t            state_r, state_n;
            logic              in_ready_r, in_ready_n;
            logic              valid_r, valid_n;
            logic [CTRL_W-1:0] main_ctrl_r, main_ctrl_n;
            logic [DATA_W-1:0] main_data_r, main_data_n;
            logic [CTRL_W-1:0] skid_ctrl_r, skid_ctrl_n;
            logic [DATA_W-1:0] skid_data_r, skid_data_n;
            logic              in_xfer_s;
            logic              out_xfer_s;

            // in_ready is a flop, so the accept decision never sees this cycle's out_ready.
            assign in_xfer_s  = in_valid & in_ready_r;
            assign out_xfer_s = valid_r & out_ready;

            // Next-state and datapath steering over the occupancy FSM.
            always_comb begin
                state_n     = state_r;
                main_ctrl_n = main_ctrl_r;
                main_data_n = main_data_r;
                skid_ctrl_n = skid_ctrl_r;
                skid_data_n = skid_data_r;
                case (state_r)
                    ST_EMPTY: begin
                        if (in_xfer_s) begin
                            main_ctrl_n = in_ctrl;
                            main_data_n = in_data;
                            state_n     = ST_HALF;
                        end else begin
                            state_n = ST_EMPTY;
                        end
                    end
                    ST_HALF: begin
                        if (in_xfer_s && out_xfer_s) begin
                            main_ctrl_n = in_ctrl;
                            main_data_n = in_data;
                        end else if (in_xfer_s) begin
                            skid_ctrl_n = in_ctrl;
                            skid_data_n = in_data;
                            state_n     = ST_FULL;
                        end else if (out_xfer_s) begin
                            main_ctrl_n = CTRL_NOP;
                            state_n     = ST_EMPTY;
                        end else begin
                            state_n = ST_HALF;
                        end
                    end
                    ST_FULL: begin
                        if (out_xfer_s) begin
                            main_ctrl_n = skid_ctrl_r;
                            main_data_n = skid_data_r;
                            state_n     = ST_HALF;
                        end else begin
                            state_n = ST_FULL;
                        end
                    end
                    default: begin
                        main_ctrl_n = CTRL_NOP;
                        state_n     = ST_EMPTY;
                    end
                endcase
                // Flush kills every held entry but leaves the data payload as it was.
                if (flush) begin
                    state_n     = ST_EMPTY;
                    main_ctrl_n = CTRL_NOP;
                    main_data_n = main_data_r;
                    skid_ctrl_n = skid_ctrl_r;
                    skid_data_n = skid_data_r;
                end else begin
                    state_n = state_n;
                end
                valid_n    = (state_n != ST_EMPTY);
                in_ready_n = (state_n != ST_FULL);
            end

            // State, handshake and payload registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_r     <= ST_EMPTY;
                    in_ready_r  <= 1'b1;
                    valid_r     <= 1'b0;
                    main_ctrl_r <= CTRL_NOP;
                    main_data_r <= {DATA_W{1'b0}};
                    skid_ctrl_r <= CTRL_NOP;
                    skid_data_r <= {DATA_W{1'b0}};
                end else begin
                    state_r     <= state_n;
                    in_ready_r  <= in_ready_n;
                    valid_r     <= valid_n;
                    main_ctrl_r <= main_ctrl_n;
                    main_data_r <= main_data_n;
                    skid_ctrl_r <= skid_ctrl_n;
                    skid_data_r <= skid_data_n;
                end
            end

            assign in_ready  = in_ready_r;
            assign out_valid = valid_r;
            assign out_ctrl  = main_ctrl_r;
            assign out_data  = main_data_r;
            assign occ       = state_r;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a SKID=1 instance and a SKID=0 instance
// driven side by side with hand-computed expectations.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_ctrl, out_ctrl;
    logic [63:0] in_data, out_data;
    logic [1:0]  occ;

    logic        in_valid0, in_ready0, out_valid0, out_ready0;
    logic [7:0]  in_ctrl0, out_ctrl0;
    logic [63:0] in_data0, out_data0;
    logic [1:0]  occ0;

    int total = 0;
    int bad   = 0;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(64), .CTRL_NOP(8'h00), .SKID(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occ(occ)
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(64), .CTRL_NOP(8'h00), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .occ(occ0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [63:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_ctrl"},  64'(out_ctrl),  64'h00);
        chk({tag, "_data"},  out_data,       64'd0);
        chk({tag, "_occ"},   64'(occ),       64'd0);
        chk({tag, "_ready"}, 64'(in_ready),  64'd1);
    endtask

    initial begin
        int idx;
        logic [7:0] c0;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'hA5; in_data = 64'hDEAD;
        in_valid0 = 1'b1; in_ctrl0 = 8'hA5; in_data0 = 64'hDEAD; out_ready0 = 1'b0;

        // Reset held two cycles with a beat presented.
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
        #1;
        reset_outputs("rst");
        chk("rst0_valid", 64'(out_valid0), 64'd0);
        chk("rst0_ready", 64'(in_ready0), 64'd1);

        // Streaming with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(8'h10 + 8'(i), 64'(i));
            #1;
            chk("strm_inready", 64'(in_ready), 64'd1);
            tick();
            chk("strm_valid", 64'(out_valid), 64'd1);
            chk("strm_ctrl",  64'(out_ctrl),  64'(8'h10 + 8'(i)));
            chk("strm_data",  out_data,       64'(i));
            chk("strm_occ",   64'(occ),       64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("strm_end_valid", 64'(out_valid), 64'd0);
        chk("strm_end_ctrl",  64'(out_ctrl),  64'h00);
        chk("strm_end_data",  out_data,       64'd9);
        chk("strm_end_occ",   64'(occ),       64'd0);

        // Backpressure: A and B fill main and skid, C waits upstream.
        out_ready = 1'b0;
        send(8'hA1, 64'hA); tick();
        send(8'hB2, 64'hB); tick();
        send(8'hC3, 64'hC); #1;
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        chk("bp_full_occ",   64'(occ),      64'd2);
        chk("bp_full_ctrl",  64'(out_ctrl), 64'hA1);
        tick();
        chk("bp_hold_occ",   64'(occ),      64'd2);
        chk("bp_hold_data",  out_data,      64'hA);
        out_ready = 1'b1;
        tick();
        chk("bp_b_data",  out_data,      64'hB);
        chk("bp_b_ctrl",  64'(out_ctrl), 64'hB2);
        chk("bp_b_ready", 64'(in_ready), 64'd1);
        chk("bp_b_occ",   64'(occ),      64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_c_valid", 64'(out_valid), 64'd1);
        chk("bp_c_data",  out_data,       64'hC);
        chk("bp_c_ctrl",  64'(out_ctrl),  64'hC3);
        tick();
        chk("bp_end_valid", 64'(out_valid), 64'd0);
        chk("bp_end_ctrl",  64'(out_ctrl),  64'h00);

        // Flush while full, with D presented in the flush cycle.
        out_ready = 1'b0;
        send(8'hE1, 64'hE1); tick();
        send(8'hE2, 64'hE2); tick();
        chk("fl_pre_occ", 64'(occ), 64'd2);
        send(8'hDD, 64'hDD); flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ",   64'(occ),       64'd0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ctrl",  64'(out_ctrl),  64'h00);
        chk("fl_ready", 64'(in_ready),  64'd1);
        chk("fl_data_held", out_data, 64'hE1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_d_valid", 64'(out_valid), 64'd0);
        end

        // Reset in the middle of a drain.
        out_ready = 1'b0;
        send(8'hF1, 64'hF1); tick();
        send(8'hF2, 64'hF2); tick();
        in_valid = 1'b0;
        chk("rd_pre_occ", 64'(occ), 64'd2);
        out_ready = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        reset_outputs("rd");
        tick();
        chk("rd_after_valid", 64'(out_valid), 64'd0);

        // SKID=0: stalled output blocks in_ready combinationally.
        in_valid0 = 1'b1; in_ctrl0 = 8'h30; in_data0 = 64'd100; out_ready0 = 1'b0;
        tick();
        in_valid0 = 1'b0;
        #1;
        chk("s0_valid",   64'(out_valid0), 64'd1);
        chk("s0_occ",     64'(occ0),       64'd1);
        chk("s0_stall",   64'(in_ready0),  64'd0);
        out_ready0 = 1'b1;
        #1;
        chk("s0_unstall", 64'(in_ready0),  64'd1);
        tick();
        chk("s0_drain_valid", 64'(out_valid0), 64'd0);
        chk("s0_drain_ctrl",  64'(out_ctrl0),  64'h00);
        chk("s0_drain_data",  out_data0,       64'd100);

        // SKID=0: continuous input while out_ready toggles; out shows beat (c+1)/2.
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            out_ready0 = c[0];
            in_valid0  = 1'b1;
            in_ctrl0   = 8'h40 + 8'(idx);
            in_data0   = 64'd200 + 64'(idx);
            #1;
            chk("tg_ready", 64'(in_ready0), (c == 0 || c % 2 == 1) ? 64'd1 : 64'd0);
            if (in_ready0) idx++;
            tick();
            c0 = 8'h40 + 8'((c + 1) / 2);
            chk("tg_valid", 64'(out_valid0), 64'd1);
            chk("tg_ctrl",  64'(out_ctrl0),  64'(c0));
            chk("tg_data",  out_data0,       64'd200 + 64'((c + 1) / 2));
        end
        in_valid0 = 1'b0; out_ready0 = 1'b1;
        tick();
        chk("tg_end_valid", 64'(out_valid0), 64'd0);
        chk("tg_end_ctrl",  64'(out_ctrl0),  64'h00);
        chk("tg_end_data",  out_data0,       64'd205);
        chk("tg_sent",      64'(idx),        64'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
